vc32_bus_mem: RTL and testbench
===============================

Name: vc32_bus_mem

Overview:
Synthesizable, parametrised memory and log-port emulator for the vc32 multiplexed external bus. It captures the address from the CPU's 8-bit output bus in two latch phases and serves byte reads and writes from a preloadable backing array. Word writes to a reserved log address go into a FIFO with a valid/ready drain and a threshold interrupt. It sits beside tt_um_vc32_cpu in the simulation harness and in FPGA bring-up builds.

Parameters:
ADDR_HI_BITS, 2, number of high address bits taken from bus_out in the latch_hi phase
MEM_AW, 12, log2 of backing-store depth in bytes
LOG_WORD, all-ones (ADDR_HI_BITS+15 bits), word address of the log port
LOG_DEPTH, 8, log FIFO entries (power of two, at least 2)
IRQ_THRESH, 1, FIFO occupancy at or above which irq asserts (1..LOG_DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bus_out  in  8  CPU address/data output bus
ind  in  1  byte select within the 16-bit word (0=low byte, 1=high byte)
write  in  1  write strobe
latch_hi  in  1  address-high latch phase
latch_lo  in  1  address-low latch phase
rdata  out  8  read data to CPU
irq  out  1  log occupancy interrupt
log_valid  out  1  FIFO head valid
log_data  out  16  FIFO head {high byte, low byte}
log_ready  in  1  consumer accepts head
log_count  out  $clog2(LOG_DEPTH+1)  FIFO occupancy
log_overflow  out  1  sticky: push attempted while FIFO full
err_latch  out  1  sticky: latch_hi and latch_lo asserted together
err_oob  out  1  sticky: access beyond the backing store
clr_err  in  1  clears all three sticky flags

Behaviour:
- One clock and a synchronous active-high reset (clk, reset). All state updates on posedge clk.
- Reset clears addr_hi, addr_med, addr_lo, the held low byte, FIFO pointers and count, and all sticky flags. The memory array is not reset; it is preloaded only through initial contents.
- Reset outputs: log_valid=0, log_count=0, irq=0, log_overflow=0, err_latch=0, err_oob=0. log_data is don't-care while log_valid=0.
- Address capture:
  - latch_hi and not latch_lo: addr_hi <= bus_out[ADDR_HI_BITS-1:0].
  - latch_lo and not latch_hi: addr_med <= bus_out, addr_lo <= bus_out[7:1].
  - Both asserted: no address update; err_latch <= 1.
- Word address = {addr_hi, addr_med, addr_lo}. Byte address = {word, ind}.
- Reads: rdata is combinational, mem[byte address] from the current address registers and ind; zero added latency.
  - Byte address at or above 2^MEM_AW: rdata = 8'h00.
  - Log address reads 8'h00.
- Writes: sampled when write=1 at the edge, using the address registers' values before any same-cycle latch update.
  - Non-log, in range: mem[byte addr] <= bus_out.
  - Out of range (non-log): write dropped; err_oob <= 1.
  - Reads never set err_oob.
- Log port (word == LOG_WORD):
  - write with ind=0: hold byte <= bus_out; memory untouched.
  - write with ind=1: push {bus_out, hold byte}.
  - Consecutive high-byte writes reuse the last held low byte.
- FIFO behaviour:
  - Pop when log_valid and log_ready.
  - Push and pop in the same cycle: count unchanged. This is legal when full, and the push is accepted.
  - Push when full and no pop: data dropped; log_overflow <= 1.
  - Pop when empty: ignored.
  - Pointers wrap modulo LOG_DEPTH.
  - log_data is the head entry; it is stable while log_valid=1 and log_ready=0.
- irq = (log_count >= IRQ_THRESH). It is combinational from the registered count.
- clr_err clears the sticky flags. A same-cycle set event wins over clr_err.
- Reset mid-transaction: a held low byte is discarded and FIFO contents are lost.

Test Plan:
- latch_hi with bus_out=8'h01, then latch_lo with 8'h23; write ind=0 8'hAA, write ind=1 8'hBB; read back -> rdata=8'hAA at ind=0 and 8'hBB at ind=1 (MEM_AW=18).
- Log write low=8'h34 then high=8'h12 with log_ready=0 -> log_valid=1, log_data=16'h1234, log_count=1, irq=1.
- LOG_DEPTH=8: push 9 words with log_ready=0 -> count=8 and log_overflow=1. Ninth push while full with log_ready=1 -> accepted, count stays 8; heads drain in order.
- latch_hi and latch_lo together with bus_out=8'hFF -> address unchanged, err_latch=1. clr_err -> 0.
- MEM_AW=12: latch an address of 0x1000 or above, write 8'h55 -> memory unchanged, rdata=8'h00, err_oob=1.
- Assert reset with two FIFO entries and a held low byte -> log_count=0, log_valid=0, flags=0; memory contents preserved.

Source files
------------

// File: rtl/vc32_bus_mem.sv
// vc32 external-bus memory and log-port emulator: two-phase address latch, byte R/W backing store, log FIFO.
// Latency: rdata is combinational from the address registers; writes, FIFO pushes and flag updates take effect at the next edge.
// Backpressure: the log FIFO drains through log_valid/log_ready; a push into a full FIFO with no pop is dropped and flagged.
module vc32_bus_mem #(
  parameter int ADDR_HI_BITS = 2,
  parameter int MEM_AW = 12,
  parameter logic [ADDR_HI_BITS+14:0] LOG_WORD = '1,
  parameter int LOG_DEPTH = 8,
  parameter int IRQ_THRESH = 1,
  localparam int CW = $clog2(LOG_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    bus_out,
  input  logic          ind,
  input  logic          write,
  input  logic          latch_hi,
  input  logic          latch_lo,
  output logic [7:0]    rdata,
  output logic          irq,
  output logic          log_valid,
  output logic [15:0]   log_data,
  input  logic          log_ready,
  output logic [CW-1:0] log_count,
  output logic          log_overflow,
  output logic          err_latch,
  output logic          err_oob,
  input  logic          clr_err
);

  localparam int WW = ADDR_HI_BITS + 15;
  localparam int BW = WW + 1;
  localparam int PW = $clog2(LOG_DEPTH);

  logic [ADDR_HI_BITS-1:0] addr_hi;
  logic [7:0]              addr_med;
  logic [6:0]              addr_lo;
  logic [WW-1:0]           word_addr;
  logic [BW-1:0]           byte_addr;
  logic [MEM_AW-1:0]       mem_idx;
  logic                    is_log;
  logic                    oob;

  logic [7:0]              mem [2**MEM_AW];
  logic [7:0]              hold_lo;
  logic [15:0]             fifo [LOG_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;

  logic                    latch_clash;
  logic                    push_req;
  logic                    push_ok;
  logic                    pop;
  logic                    full;
  logic                    oob_write;

  assign word_addr = {addr_hi, addr_med, addr_lo};
  assign byte_addr = {word_addr, ind};
  assign mem_idx   = MEM_AW'(byte_addr);
  assign is_log    = (word_addr == LOG_WORD);
  // Any set bit above the store's index width means the access misses the array.
  assign oob       = (BW > MEM_AW) && ((byte_addr >> MEM_AW) != '0);

  assign latch_clash = latch_hi && latch_lo;
  assign full        = (log_count == CW'(LOG_DEPTH));
  assign log_valid   = (log_count != '0);
  assign log_data    = fifo[rd_ptr];
  assign pop         = log_valid && log_ready;
  assign push_req    = write && is_log && ind;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok     = push_req && (!full || pop);
  assign oob_write   = write && !is_log && oob;
  assign irq         = (log_count >= CW'(IRQ_THRESH));

  // Combinational read: log word and out-of-range addresses read as zero.
  always_comb begin
    rdata = 8'h00;
    if (!is_log && !oob) rdata = mem[mem_idx];
  end

  // Backing store: never reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!reset && write && !is_log && !oob) mem[mem_idx] <= bus_out;
  end

  // FIFO storage: data only, occupancy is tracked in the control block.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo[wr_ptr] <= {bus_out, hold_lo};
  end

  // Address latches, held low byte, FIFO pointers/count and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hi      <= '0;
      addr_med     <= '0;
      addr_lo      <= '0;
      hold_lo      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_count    <= '0;
      log_overflow <= 1'b0;
      err_latch    <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      if (latch_hi && !latch_lo) addr_hi <= bus_out[ADDR_HI_BITS-1:0];
      if (latch_lo && !latch_hi) begin
        addr_med <= bus_out;
        addr_lo  <= bus_out[7:1];
      end

      if (write && is_log && !ind) hold_lo <= bus_out;

      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      log_count <= log_count + CW'(1);
      else if (pop && !push_ok) log_count <= log_count - CW'(1);

      // Set events take priority over clr_err.
      if (push_req && !push_ok) log_overflow <= 1'b1;
      else if (clr_err)         log_overflow <= 1'b0;
      if (latch_clash)          err_latch <= 1'b1;
      else if (clr_err)         err_latch <= 1'b0;
      if (oob_write)            err_oob <= 1'b1;
      else if (clr_err)         err_oob <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vc32_bus_mem.sv
// Directed bench for vc32_bus_mem: a vector table plus hand sequences for FIFO fill/drain and reset.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// Default parameters: ADDR_HI_BITS=2, MEM_AW=12, LOG_DEPTH=8, IRQ_THRESH=1.
module tb_vc32_bus_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  bus_out;
  logic        ind, write, latch_hi, latch_lo;
  logic [7:0]  rdata;
  logic        irq, log_valid, log_ready;
  logic [15:0] log_data;
  logic [3:0]  log_count;
  logic        log_overflow, err_latch, err_oob, clr_err;

  int n_vec = 0;
  int n_bad = 0;

  vc32_bus_mem dut (
    .clk(clk), .reset(reset), .bus_out(bus_out), .ind(ind), .write(write),
    .latch_hi(latch_hi), .latch_lo(latch_lo), .rdata(rdata), .irq(irq),
    .log_valid(log_valid), .log_data(log_data), .log_ready(log_ready),
    .log_count(log_count), .log_overflow(log_overflow), .err_latch(err_latch),
    .err_oob(err_oob), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lh, ll, wr, ind;
    logic [7:0]  bus;
    logic        rdy, clr;
    logic        ck_rd;
    logic [7:0]  rd;
    logic        vld;
    logic        ck_dat;
    logic [15:0] dat;
    logic [3:0]  cnt;
    logic        irq, ovf, el, eoob;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic lh, logic ll, logic wr, logic i, logic [7:0] bus,
                              logic rdy, logic clr, logic ck_rd, logic [7:0] rd,
                              logic vld, logic ck_dat, logic [15:0] dat, logic [3:0] cnt,
                              logic iq, logic ovf, logic el, logic eoob);
    vec_t v;
    v.lh = lh; v.ll = ll; v.wr = wr; v.ind = i; v.bus = bus; v.rdy = rdy; v.clr = clr;
    v.ck_rd = ck_rd; v.rd = rd; v.vld = vld; v.ck_dat = ck_dat; v.dat = dat;
    v.cnt = cnt; v.irq = iq; v.ovf = ovf; v.el = el; v.eoob = eoob;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the rising edge take them, stop on the next falling edge.
  task automatic drv(input logic lh, input logic ll, input logic wr, input logic i,
                     input logic [7:0] bus, input logic rdy, input logic clr);
    latch_hi = lh; latch_lo = ll; write = wr; ind = i;
    bus_out = bus; log_ready = rdy; clr_err = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    latch_hi = 0; latch_lo = 0; write = 0; ind = 0; bus_out = 0; log_ready = 0; clr_err = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_head;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("rst_log_valid", log_valid, 0);
    chk("rst_log_count", log_count, 0);
    chk("rst_irq", irq, 0);
    chk("rst_overflow", log_overflow, 0);
    chk("rst_err_latch", err_latch, 0);
    chk("rst_err_oob", err_oob, 0);
    reset = 1'b0;

    //          lh ll wr in bus    rdy clr ckrd rd     vld ckd dat       cnt irq ovf el eoob
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    // addr_med=05, addr_lo=02 -> byte 1284/1285, inside 4 KiB
    tbl.push_back(mk(0, 1, 0, 0, 8'h05, 0, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'hAA, 0, 0, 1, 8'hAA, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'hBB, 0, 0, 1, 8'hBB, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 1, 8'hAA, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 1, 8'hBB, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    // both latches: address kept, err_latch set
    tbl.push_back(mk(1, 1, 0, 0, 8'hFF, 0, 0, 1, 8'hAA, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 1, 1, 8'hBB, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    // addr_med=23, addr_lo=11 -> byte 8994, beyond 4 KiB
    tbl.push_back(mk(0, 1, 0, 0, 8'h23, 0, 0, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h55, 0, 0, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 1));
    // set beats clear for err_latch; err_oob clears
    tbl.push_back(mk(1, 1, 0, 0, 8'hFF, 0, 1, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h05, 0, 0, 1, 8'hAA, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    // move to the log word {3, FF, 7F}
    tbl.push_back(mk(1, 0, 0, 1, 8'h03, 0, 0, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 0, 0, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h34, 0, 0, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h12, 0, 0, 1, 8'h00, 1, 1, 16'h1234, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h56, 0, 0, 1, 8'h00, 1, 1, 16'h1234, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1, 1, 16'h5634, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t v;
      v = tbl[k];
      drv(v.lh, v.ll, v.wr, v.ind, v.bus, v.rdy, v.clr);
      if (v.ck_rd) chk($sformatf("v%0d_rdata", k), rdata, v.rd);
      chk($sformatf("v%0d_log_valid", k), log_valid, v.vld);
      if (v.ck_dat) chk($sformatf("v%0d_log_data", k), log_data, v.dat);
      chk($sformatf("v%0d_log_count", k), log_count, v.cnt);
      chk($sformatf("v%0d_irq", k), irq, v.irq);
      chk($sformatf("v%0d_overflow", k), log_overflow, v.ovf);
      chk($sformatf("v%0d_err_latch", k), err_latch, v.el);
      chk($sformatf("v%0d_err_oob", k), err_oob, v.eoob);
    end

    // Fill: nine pushes with no drain; the ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      drv(0, 0, 1, 0, 8'(i), 0, 0);
      drv(0, 0, 1, 1, 8'(8'hA0 + i), 0, 0);
      if (i == 7) begin
        chk("fill8_count", log_count, 8);
        chk("fill8_overflow", log_overflow, 0);
      end
    end
    chk("fill9_count", log_count, 8);
    chk("fill9_overflow", log_overflow, 1);
    chk("fill9_head", log_data, 16'hA000);
    drv(0, 0, 0, 0, 8'h00, 0, 1);
    chk("ovf_clr", log_overflow, 0);
    // Push while full with a simultaneous pop is accepted.
    drv(0, 0, 1, 0, 8'h09, 0, 0);
    drv(0, 0, 1, 1, 8'hA9, 1, 0);
    chk("full_pp_count", log_count, 8);
    chk("full_pp_overflow", log_overflow, 0);
    for (int k = 1; k <= 8; k++) begin
      exp_head = (k == 8) ? 16'hA909 : {8'(8'hA0 + k), 8'(k)};
      chk($sformatf("drain%0d_head", k), log_data, exp_head);
      drv(0, 0, 0, 0, 8'h00, 1, 0);
    end
    chk("drain_count", log_count, 0);
    chk("drain_valid", log_valid, 0);

    // Reset with two entries, a held low byte and a sticky flag pending.
    drv(0, 0, 1, 0, 8'h11, 0, 0);
    drv(0, 0, 1, 1, 8'h22, 0, 0);
    drv(0, 0, 1, 1, 8'h33, 0, 0);
    drv(0, 0, 1, 0, 8'h77, 0, 0);
    drv(1, 1, 0, 0, 8'h00, 0, 0);
    chk("pre_rst_count", log_count, 2);
    chk("pre_rst_err_latch", err_latch, 1);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_count", log_count, 0);
    chk("mid_rst_valid", log_valid, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_err_latch", err_latch, 0);
    drv(0, 1, 0, 0, 8'h05, 0, 0);
    chk("mem_kept_lo", rdata, 8'hAA);
    drv(0, 0, 0, 1, 8'h00, 0, 0);
    chk("mem_kept_hi", rdata, 8'hBB);
    drv(1, 0, 0, 0, 8'h03, 0, 0);
    drv(0, 1, 0, 0, 8'hFF, 0, 0);
    drv(0, 0, 1, 1, 8'h99, 0, 0);
    chk("hold_cleared_head", log_data, 16'h9900);
    chk("hold_cleared_count", log_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
